jk_bank_sequencer: RTL
======================

# jk_bank_sequencer

Controller that drives the J/K inputs of an external bank of WIDTH JK flip-flops. The flip-flops are the SR-based JK cells sharing the same clock. The sequencer keeps a shadow copy of the bank state and steps the bank one excitation per cycle: counting up, counting down to a programmed limit, loading the limit directly, or holding. It checks the bank's q feedback against the shadow every cycle and flags divergence. It sits between the command/control logic and the flip-flop bank.

## Interface
Parameters:
- WIDTH, 4, number of JK flip-flops in the controlled bank

Ports:
- clock  input  1  single clock; the JK bank uses the same edge
- reset  input  1  asynchronous, active-low
- start  input  1  command strobe; sampled only in IDLE
- mode  input  2  00 hold, 01 up, 10 down, 11 load; latched on accepted start
- limit  input  WIDTH  target value (terminal count, or load value); latched on accepted start
- clear_err  input  1  leaves ERR
- q  input  WIDTH  feedback from the bank outputs
- j  output  WIDTH  J excitation to the bank
- k  output  WIDTH  K excitation to the bank
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- err  output  1  high in ERR
- steps  output  WIDTH+1  number of excitations issued by the current or last command

## Operation
- States: IDLE, RUN, DONE, ERR.
- Excitation for each bit, from current shadow bit c and next bit n:
  - j = ~c & n
  - k = c & ~n
  - Toggle (j=k=1) is never driven.
  - Outside RUN steps, j=k=0.
- IDLE:
  - j=k=0.
  - On start: shadow<=q, latch mode and limit, steps<=0, go to RUN.
- RUN, each cycle, in priority order:
  1. If q≠shadow: go to ERR, j=k=0.
  2. Hold mode: issue no step, go to DONE.
  3. If shadow==limit: go to DONE, j=k=0.
  4. Otherwise compute next and drive j/k = excite(shadow, next). Then shadow<=next and steps<=steps+1.
     - Up: next = shadow+1, modulo 2^WIDTH (all-ones wraps to 0).
     - Down: next = shadow−1, modulo 2^WIDTH (0 wraps to all-ones).
     - Load: next = limit (single step).
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - q is still checked; a mismatch goes to ERR instead of IDLE.
- ERR:
  - j=k=0; err held high.
  - Goes to IDLE on clear_err.
  - start is ignored in ERR.
- start outside IDLE is ignored; mode and limit changes while busy have no effect.
- Every command terminates: up/down take at most 2^WIDTH−1 steps.

## Timing
- Reset (asynchronous, active-low): state=IDLE; j=k=0; busy=0, done=0, err=0; shadow=0; steps=0.
- Reset asserted mid-RUN aborts the command immediately. The bank may hold a partial value; the next start resynchronizes the shadow from q.
- start accepted at edge t → busy=1 from t. The first j/k are valid during cycle t..t+1, and the bank updates at edge t+1.
- q is compared one cycle after each excitation: the bank and shadow update on the same edge.
- Up/down from value v to limit L (L≠v): steps=|distance| and busy lasts steps+1 cycles. DONE follows in the next cycle, and IDLE the cycle after.
- start with q==limit (up/down/load): zero steps, RUN for 1 cycle, then DONE.
- Hold: RUN 1 cycle, steps=0, then DONE.
- Minimum spacing between accepted starts: 3 cycles (RUN, DONE, IDLE).

## Structure
- Package jk_seq_pkg holds:
  - state enum (IDLE, RUN, DONE, ERR)
  - mode constants MODE_HOLD, MODE_UP, MODE_DOWN, MODE_LOAD
- Sub-module jk_excite is combinational, parameterized by WIDTH: (cur, next) → (j, k). It is reused by future bank controllers.
- The top holds the FSM, shadow register, step counter and q comparator.

## Test plan
- WIDTH=4, bank at 0011, start up, limit 0110 → j/k step 0011→0100→0101→0110; steps=3; done pulses once; err=0; q ends at 0110.
- Bank at 0001, start down, limit 1110 → wraps through 0000, 1111 to 1110; steps=3. The 0000→1111 step drives j=1111, k=0000.
- Bank at 1010, start load, limit 0101 → one step with j=0101, k=1010; steps=1; done pulses; then IDLE.
- Start up, limit 1000; force q bit 0 wrong during RUN → ERR next cycle, j=k=0, err=1. start is ignored; clear_err returns to IDLE.
- Start up, limit 1111 from 0000; assert reset at step 5 → all outputs 0 immediately. After release, start resyncs shadow to q and the count completes correctly.
- Start with q==limit, and hold mode → zero steps, done one cycle after busy; a second start pulse during busy is ignored.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types for JK flip-flop bank controllers.
// This package holds the controller states and the command mode encodings.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// JK excitation for a bank of flip-flops, moving from state cur to state nxt.
// This block only sets or resets bits, so it never produces the toggle code j=k=1.
module jk_excite #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  assign j = ~cur & nxt;
  assign k = cur & ~nxt;

endmodule

// File: rtl/jk_bank_sequencer.sv
// Steps an external JK flip-flop bank by one excitation per cycle (up, down, load, hold).
// It keeps a shadow of the bank and flags any cycle where the bank's q diverges from it.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             clear_err,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH:0]   steps
);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] shadow, next_val, limit_q;
  logic [1:0]       mode_q;
  logic             step_en;
  logic [WIDTH-1:0] ex_j, ex_k;

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .cur (shadow),
    .nxt (next_val),
    .j   (ex_j),
    .k   (ex_k)
  );

  always_comb begin
    next_val = shadow;
    unique case (mode_q)
      MODE_UP:   next_val = shadow + WIDTH'(1);
      MODE_DOWN: next_val = shadow - WIDTH'(1);
      MODE_LOAD: next_val = limit_q;
      default:   next_val = shadow;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    step_en   = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (q != shadow)                                  state_nxt = ERR;
        else if (mode_q == MODE_HOLD || shadow == limit_q) state_nxt = DONE;
        else                                              step_en   = 1'b1;
      end
      DONE: state_nxt = (q != shadow) ? ERR : IDLE;
      ERR:  if (clear_err) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shadow  <= '0;
      mode_q  <= MODE_HOLD;
      limit_q <= '0;
      steps   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        // Resynchronise from the bank itself: after an aborted command it may hold any value.
        shadow  <= q;
        mode_q  <= mode;
        limit_q <= limit;
        steps   <= '0;
      end else if (step_en) begin
        shadow <= next_val;
        steps  <= steps + (WIDTH+1)'(1);
      end
    end
  end

  assign j    = step_en ? ex_j : '0;
  assign k    = step_en ? ex_k : '0;
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign err  = (state == ERR);

endmodule
